mux_arbiter: RTL
================

MUX_ARBITER -- requirements
Module: mux_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one mux tree, 2..16.
REQ-002 SHALL have parameter N, default 64: mux tree input count.
REQ-003 SHALL have parameter W, default 8: mux data width.
REQ-004 SHALL have parameter BR, default 8: mux tree branching ratio.
REQ-005 SHALL have parameter ADRB, default $clog2(N): address width.
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-008 SHALL have port req_valid  input  NREQ  per-requester lookup request.
REQ-009 SHALL have port req_adr  input  NREQ x ADRB  per-requester address, unpacked array [NREQ].
REQ-010 SHALL have port req_ready  output  NREQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
REQ-011 SHALL have port mux_adr  output  ADRB  address driven to the mux tree.
REQ-012 SHALL have port mux_dout  input  W  registered data from the mux tree.
REQ-013 SHALL have port rsp_valid  output  1  one-cycle response pulse.
REQ-014 SHALL have port rsp_id  output  $clog2(NREQ)  index of the requester owning the response.
REQ-015 SHALL have port rsp_data  output  W  captured mux_dout.
REQ-016 SHALL have port busy  output  1  high while a lookup is in flight.

Function
REQ-017 SHALL compute LAT = number of mux tree register stages: 1 if N<=BR, else 1+LAT(N/BR) (64/8 -> 2).
REQ-018 SHALL hold mux_adr constant for LAT+1 consecutive cycles per lookup, because every tree stage samples its address slice from the same, undelayed address.
REQ-019 SHALL use an FSM with states IDLE, HOLD, CAPTURE.
REQ-020 IDLE: if any req_valid is high, it SHALL assert req_ready for exactly one requester (combinational, same cycle), register its req_adr into mux_adr and its index, load the counter with LAT-1, and go to HOLD; otherwise it stays in IDLE with req_ready=0.
REQ-021 HOLD: it SHALL decrement the counter each cycle, go to CAPTURE when the counter is 0, and keep req_ready=0.
REQ-022 CAPTURE: it SHALL register mux_dout into rsp_data, pulse rsp_valid for one cycle next cycle with rsp_id = granted index, and return to IDLE.
REQ-023 The lookup interval SHALL be LAT+2 cycles from grant to the next possible grant; rsp_valid SHALL follow grant by LAT+2 cycles.
REQ-024 Arbitration SHALL be round-robin: search starts at (last grant + 1) mod NREQ; the pointer updates only on a grant; after reset the pointer starts at requester 0.
REQ-025 Requesters SHALL hold req_valid/req_adr until granted; deasserting req_valid before grant SHALL be legal and drops that request.
REQ-026 A req_adr >= N SHALL be forwarded unchanged; the mux behaviour for it is undefined.
REQ-027 busy SHALL be high in HOLD and CAPTURE, and in the cycle rsp_valid is high only if a new grant occurred.
REQ-028 Each requester SHALL be granted at most once per NREQ grants while all request continuously.

Reset
REQ-029 rst_n low SHALL asynchronously force the FSM to IDLE, counter=0, rr pointer=0, mux_adr=0, rsp_valid=0, rsp_id=0, rsp_data=0.
REQ-030 Reset mid-lookup SHALL discard the in-flight lookup with no rsp_valid; the first grant after rst_n rises SHALL occur no earlier than the first edge with rst_n high.

Structure
REQ-031 The function computing LAT from N and BR SHALL live in the shared mux package (mux_pkg), which the mux tree and testbench also use.
REQ-032 The round-robin arbiter SHALL be one sub-module, rr_arbiter (NREQ req, advance enable, one-hot grant, index out).

Verification
REQ-033 Single request: N=64, BR=8, req_valid[2]=1, adr=37, din[37]=0xA5 -> req_ready[2] in cycle 0, mux_adr=37 for cycles 1-3, rsp_valid cycle 4 with id=2 and data=0xA5.
REQ-034 All four requesting continuously with distinct addresses -> grants 0,1,2,3,0 spaced 4 cycles apart, each response data matching its address.
REQ-035 N=8, BR=8 (LAT=1) -> rsp_valid 3 cycles after grant; back-to-back grants 3 cycles apart.
REQ-036 rst_n pulsed low in HOLD -> outputs zero immediately, no rsp_valid, next grant goes to requester 0.
REQ-037 req_valid[1] withdrawn while requester 0 is served -> requester 1 is never granted and no response carries id=1.
REQ-038 Adversarial: requester 3 toggles req_valid every cycle while 0-2 are held high -> no starvation, and every granted lookup returns the correct data.

Source files
------------

// File: rtl/mux_pkg.sv
`default_nettype none
// ============================================================================
// mux_pkg : shared mux-tree definitions (latency helper, arbiter FSM states)
// Rev 1.0
// ============================================================================
package mux_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        HOLD    = 2'd1,
        CAPTURE = 2'd2
    } arb_state_t;

    // Register stages of an N-input tree built from BR-input stages:
    // 1 if N <= BR, else 1 + stages(N / BR).
    function automatic int mux_lat(input int n, input int br);
        int m;
        int lat;
        m   = n;
        lat = 1;
        for (int k = 0; k < 32; k++) begin
            if (br > 1 && m > br) begin
                m   = m / br;
                lat = lat + 1;
            end
        end
        return lat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mux_arbiter_if.sv
`default_nettype none
// ============================================================================
// mux_arbiter_if : requester, mux-tree and response signals of mux_arbiter
// Rev 1.0
// ============================================================================
interface mux_arbiter_if #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int ADRB = 6
);
    logic [NREQ-1:0]         req_valid;
    logic [ADRB-1:0]         req_adr [NREQ];
    logic [NREQ-1:0]         req_ready;
    logic [ADRB-1:0]         mux_adr;
    logic [W-1:0]            mux_dout;
    logic                    rsp_valid;
    logic [$clog2(NREQ)-1:0] rsp_id;
    logic [W-1:0]            rsp_data;
    logic                    busy;

    modport master (
        output req_valid, req_adr, mux_dout,
        input  req_ready, mux_adr, rsp_valid, rsp_id, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_adr, mux_dout,
        output req_ready, mux_adr, rsp_valid, rsp_id, rsp_data, busy
    );
endinterface
`default_nettype wire

// File: rtl/mux_arbiter_rr.sv
`default_nettype none
// ============================================================================
// rr_arbiter : round-robin one-hot arbiter, search starts after last grant
// Rev 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req,
    input  logic                    advance,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] idx
);
    localparam int IDW = $clog2(NREQ);

    logic [IDW-1:0] r_ptr;
    logic           w_found;
    int             w_cand;

    always_comb begin
        grant   = '0;
        idx     = '0;
        w_found = 1'b0;
        w_cand  = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_cand = int'(r_ptr) + i;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                grant[w_cand]  = 1'b1;
                idx            = IDW'(w_cand);
            end
        end
    end

    // Pointer moves only when a grant is actually taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (idx == IDW'(NREQ - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
// mux_arbiter : shares one registered mux tree among NREQ requesters
// Rev 1.0
// ============================================================================
module mux_arbiter
    import mux_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int N    = 64,
    parameter int W    = 8,
    parameter int BR   = 8,
    parameter int ADRB = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    mux_arbiter_if.slave bus
);
    localparam int LAT = mux_lat(N, BR);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(LAT + 1);
    localparam logic [CW-1:0] c_cnt_load = CW'(LAT - 1);

    arb_state_t      r_state;
    arb_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            r_run;
    logic [NREQ-1:0] w_req;
    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_adv;
    logic [IDW-1:0]  r_id;
    logic [ADRB-1:0] r_madr;
    logic            r_rsp_valid;
    logic [IDW-1:0]  r_rsp_id;
    logic [W-1:0]    r_rsp_data;

    // r_run keeps grants off until the first clock edge after reset release.
    assign w_req = bus.req_valid & {NREQ{(r_state == IDLE) && r_run}};
    assign w_adv = |w_grant;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (w_req),
        .advance (w_adv),
        .grant   (w_grant),
        .idx     (w_gidx)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_adv) begin
                    w_state_nxt = HOLD;
                    w_cnt_nxt   = c_cnt_load;
                end
            end
            HOLD: begin
                if (r_cnt == '0) begin
                    w_state_nxt = CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            CAPTURE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Address is captured once per grant and held unchanged until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run       <= 1'b0;
            r_madr      <= '0;
            r_id        <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_run       <= 1'b1;
            r_rsp_valid <= (r_state == CAPTURE);
            if (w_adv) begin
                r_madr <= bus.req_adr[w_gidx];
                r_id   <= w_gidx;
            end
            if (r_state == CAPTURE) begin
                r_rsp_data <= bus.mux_dout;
                r_rsp_id   <= r_id;
            end
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.mux_adr   = r_madr;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_rsp_id;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.busy      = (r_state != IDLE) | w_adv;

endmodule
`default_nettype wire
